// File: rtl/expr_pkg.sv
// -----------------------------------------------------------------------------
// expr_pkg
// Shared definitions for expression-string producers and consumers:
//   - ASCII constants for the characters an expression string can contain
//   - operator encoding (0 = plus, 1 = mul)
//   - transmitter FSM state enum
//   - small helpers that map a digit / operator bit to its ASCII character
// -----------------------------------------------------------------------------
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  typedef enum logic {
    OP_PLUS = 1'b0,
    OP_MUL  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_OP,
    ST_TERM,
    ST_FIN
  } tx_state_e;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? CH_MUL : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_req_check.sv
// -----------------------------------------------------------------------------
// expr_req_check
// Combinational validity check for an expression request.
//   len    : operand count, legal range 1..MAX_TERMS
//   digits : operand i in bits [4i+3:4i], legal values 0..9
//   req_ok : 1 when len is in range and every operand below len is a decimal
//            digit; operands at positions >= len are don't-care.
// -----------------------------------------------------------------------------
module expr_req_check #(
  parameter int MAX_TERMS = 8,
  parameter int LEN_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic [LEN_W-1:0]       len,
  input  logic [4*MAX_TERMS-1:0] digits,
  output logic                   req_ok
);

  // NOTE: req_ok gets a full assignment before the loop can only clear it,
  // so every path through the block drives it and no latch is inferred.
  always_comb begin
    req_ok = (len != '0) && (len <= LEN_W'(MAX_TERMS));
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((LEN_W'(i) < len) && (digits[4*i +: 4] > 4'd9)) begin
        req_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/expr_string_tx.sv
// -----------------------------------------------------------------------------
// expr_string_tx
// Serialises a latched expression (operands + operators) into an ASCII
// character stream of the form  digit (op digit)* ['=']  over a valid/ready
// handshake, one character per accepted beat.
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous active-high reset, dominates all other inputs
//   start      transmit request, sampled only in IDLE
//   len        operand count (1..MAX_TERMS)
//   digits     operand i in bits [4i+3:4i]
//   ops        bit i = operator between operand i and i+1 (0 '+', 1 '*')
//   out_char   ASCII character, 8'h00 whenever out_valid is low
//   out_valid  out_char holds a character
//   out_ready  consumer accepts the character when out_valid && out_ready
//   busy       FSM is outside IDLE
//   done       one-cycle pulse after the last character is accepted
//   err        one-cycle pulse when a start request is rejected
//
// All outputs come straight from flops; out_ready only steers the next state.
// -----------------------------------------------------------------------------
module expr_string_tx
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter bit TERM_EN   = 1'b1,
  parameter int LEN_W     = $clog2(MAX_TERMS + 1),
  parameter int OPS_W     = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [OPS_W-1:0]       ops,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  tx_state_e              state_q;
  logic [LEN_W-1:0]       idx_q;
  logic [LEN_W-1:0]       len_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [OPS_W-1:0]       ops_q;
  logic [7:0]             out_char_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   req_ok;
  logic                   accept;
  logic [LEN_W-1:0]       idx_d;
  logic [LEN_W-1:0]       last_idx;
  logic [3:0]             next_digit;
  logic                   cur_op;

  expr_req_check #(
    .MAX_TERMS (MAX_TERMS),
    .LEN_W     (LEN_W)
  ) u_req_check (
    .len    (len),
    .digits (digits),
    .req_ok (req_ok)
  );

  assign accept     = out_valid_q & out_ready;
  assign idx_d      = idx_q + LEN_W'(1);
  assign last_idx   = len_q - LEN_W'(1);
  // Shifts instead of variable part-selects keep the index width independent
  // of the vector width.
  assign next_digit = 4'(digits_q >> {idx_d, 2'b00});
  assign cur_op     = 1'(ops_q >> idx_q);

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values of the others, like real flops.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (req_ok) begin
              // NOTE: the operand registers are left out of reset; they are
              // only ever read after this load, so resetting them buys nothing.
              len_q       <= len;
              digits_q    <= digits;
              ops_q       <= ops;
              idx_q       <= '0;
              state_q     <= ST_DIGIT;
              out_valid_q <= 1'b1;
              out_char_q  <= digit_char(digits[3:0]);
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_DIGIT: begin
          if (accept) begin
            if (idx_q == last_idx) begin
              if (TERM_EN) begin
                state_q    <= ST_TERM;
                out_char_q <= CH_EQ;
              end else begin
                state_q     <= ST_FIN;
                out_valid_q <= 1'b0;
                out_char_q  <= 8'h00;
                done_q      <= 1'b1;
              end
            end else begin
              state_q    <= ST_OP;
              out_char_q <= op_char(cur_op);
            end
          end
        end

        ST_OP: begin
          if (accept) begin
            idx_q      <= idx_d;
            state_q    <= ST_DIGIT;
            out_char_q <= digit_char(next_digit);
          end
        end

        ST_TERM: begin
          if (accept) begin
            state_q     <= ST_FIN;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            done_q      <= 1'b1;
          end
        end

        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_char_q  <= 8'h00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_string_tx.sv
// -----------------------------------------------------------------------------
// tb_expr_string_tx
// Directed self-checking bench for expr_string_tx. Two instances: dut with the
// '=' terminator enabled and dut0 without it. Inputs are driven and outputs
// observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_expr_string_tx;

  localparam int MT = 8;
  localparam int LW = 4;
  localparam int OW = 7;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic          start0;
  logic          out_ready;
  logic [LW-1:0] len;
  logic [4*MT-1:0] digits;
  logic [OW-1:0] ops;

  logic [7:0] out_char, out_char0;
  logic       out_valid, out_valid0;
  logic       busy, busy0, done, done0, err, err0;

  int checks   = 0;
  int failures = 0;

  // collector results
  bit         sel;
  string      got_s;
  int         first_v, last_acc, done_c;
  bit         stable, idle_zero;

  logic [7:0] m_char;
  logic       m_valid, m_done;

  always #5 clk = ~clk;

  always_comb begin
    m_char  = sel ? out_char0  : out_char;
    m_valid = sel ? out_valid0 : out_valid;
    m_done  = sel ? done0      : done;
  end

  expr_string_tx #(.MAX_TERMS(MT), .TERM_EN(1'b1)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .digits    (digits),
    .ops       (ops),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  expr_string_tx #(.MAX_TERMS(MT), .TERM_EN(1'b0)) dut0 (
    .clk       (clk),
    .clr       (clr),
    .start     (start0),
    .len       (len),
    .digits    (digits),
    .ops       (ops),
    .out_char  (out_char0),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .busy      (busy0),
    .done      (done0),
    .err       (err0)
  );

  // Runs the handshake until done (or a 64-cycle budget) and records what was
  // accepted. Cycle numbers count falling edges after the call; the start
  // request must already have been sampled. stall_at/stall_len hold out_ready
  // low for stall_len beats when stall_at characters have been accepted;
  // poke_at raises start with different operands mid-stream.
  task automatic collect(input bit use0, input int stall_at, input int stall_len,
                         input int poke_at);
    int acc = 0;
    int stl = 0;
    bit hold = 1'b0;
    logic [7:0] prev = 8'h00;
    sel = use0;
    got_s = "";
    first_v = -1; last_acc = -1; done_c = -1;
    stable = 1'b1; idle_zero = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (use0) start0 = (c == poke_at); else start = (c == poke_at);
      if (c == poke_at) begin
        len    = 4'd2;
        digits = 32'h9999_9999;
        ops    = '1;
      end
      if (m_done) begin
        done_c = c;
        if (m_valid !== 1'b0 || m_char !== 8'h00) idle_zero = 1'b0;
        break;
      end
      if (hold && (m_valid !== 1'b1 || m_char !== prev)) stable = 1'b0;
      hold = 1'b0;
      if (!m_valid && m_char !== 8'h00) idle_zero = 1'b0;
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        if (acc == stall_at && stl < stall_len) begin
          out_ready = 1'b0;
          stl++;
          hold = 1'b1;
          prev = m_char;
        end else begin
          out_ready = 1'b1;
          got_s = $sformatf("%s%c", got_s, m_char);
          acc++;
          last_acc = c;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; start0 = 1'b0; out_ready = 1'b1;
    len = '0; digits = '0; ops = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_char, out_valid, busy, done, err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut: got char=%h v=%b busy=%b done=%b err=%b, want all 0",
               out_char, out_valid, busy, done, err);
    end
    checks++;
    if ({out_char0, out_valid0, busy0, done0, err0} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut0: got char=%h v=%b busy=%b done=%b err=%b, want all 0",
               out_char0, out_valid0, busy0, done0, err0);
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    len = 4'd3; digits = 32'h0000_0321; ops = 7'b000_0010; start = 1'b1;
    collect(1'b0, -1, 0, -1);
    checks++;
    if (got_s != "1+2*3=") begin
      failures++; $display("FAIL basic_string: got '%s', want '1+2*3='", got_s);
    end
    checks++;
    if (first_v != 0 || last_acc != 5 || done_c != 6) begin
      failures++;
      $display("FAIL basic_timing: got first=%0d last=%0d done=%0d, want 0/5/6",
               first_v, last_acc, done_c);
    end
    checks++;
    if (!idle_zero) begin
      failures++; $display("FAIL basic_idle_char: got nonzero char while invalid, want 00");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL basic_after: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_single_no_term();
    len = 4'd1; digits = 32'h0000_0007; ops = '0; start0 = 1'b1;
    collect(1'b1, -1, 0, -1);
    checks++;
    if (got_s != "7") begin
      failures++; $display("FAIL single_string: got '%s', want '7'", got_s);
    end
    checks++;
    if (first_v != 0 || done_c != 1) begin
      failures++;
      $display("FAIL single_timing: got first=%0d done=%0d, want 0/1", first_v, done_c);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    len = 4'd3; digits = 32'h0000_0321; ops = 7'b000_0010; start = 1'b1;
    collect(1'b0, 1, 3, -1);
    checks++;
    if (got_s != "1+2*3=") begin
      failures++; $display("FAIL stall_string: got '%s', want '1+2*3='", got_s);
    end
    checks++;
    if (!stable) begin
      failures++; $display("FAIL stall_hold: got char/valid changed during stall, want held");
    end
    checks++;
    if (done_c != 9) begin
      failures++; $display("FAIL stall_done: got done at %0d, want 9", done_c);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_request();
    logic [LW-1:0]   bad_len [3] = '{4'd2, 4'd0, 4'd9};
    logic [4*MT-1:0] bad_dig [3] = '{32'h0000_00A5, 32'h0000_0001, 32'h0000_0001};
    for (int k = 0; k < 3; k++) begin
      len = bad_len[k]; digits = bad_dig[k]; ops = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bad_req%0d: got err=%b v=%b busy=%b, want 1/0/0", k, err, out_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bad_req%0d_after: got err=%b v=%b busy=%b, want 0/0/0",
                 k, err, out_valid, busy);
      end
    end
    // Invalid value beyond len is ignored.
    len = 4'd2; digits = 32'h00A0_0021; ops = '0; start = 1'b1;
    collect(1'b0, -1, 0, -1);
    checks++;
    if (got_s != "1+2=" || done_c != 4) begin
      failures++;
      $display("FAIL ignored_high_digit: got '%s' done=%0d, want '1+2=' done=4", got_s, done_c);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    len = 4'd3; digits = 32'h0000_0321; ops = 7'b000_0010; start = 1'b1;
    collect(1'b0, -1, 0, 2);
    checks++;
    if (got_s != "1+2*3=") begin
      failures++; $display("FAIL busy_start: got '%s', want '1+2*3='", got_s);
    end
    // Now in FIN: a start here is ignored, the one in the following cycle wins.
    len = 4'd2; digits = 32'h0000_0054; ops = 7'b000_0001; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL fin_start: got busy=%b v=%b, want 0/0", busy, out_valid);
    end
    collect(1'b0, -1, 0, -1);
    checks++;
    if (got_s != "4*5=" || first_v != 0) begin
      failures++;
      $display("FAIL restart: got '%s' first=%0d, want '4*5=' first=0", got_s, first_v);
    end
    @(negedge clk);
  endtask

  task automatic test_clr_mid();
    bit saw_done = 1'b0;
    len = 4'd3; digits = 32'h0000_0321; ops = 7'b000_0010; start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_char !== 8'h31) begin
      failures++; $display("FAIL clr_first: got v=%b char=%h, want 1/31", out_valid, out_char);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_char !== 8'h2B) begin
      failures++; $display("FAIL clr_second: got v=%b char=%h, want 1/2b", out_valid, out_char);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_char !== 8'h00 || done !== 1'b0) begin
      failures++;
      $display("FAIL clr_state: got v=%b busy=%b char=%h done=%b, want 0/0/00/0",
               out_valid, busy, out_char, done);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++; $display("FAIL clr_quiet: got done/valid after clear, want none");
    end
    len = 4'd2; digits = 32'h0000_0054; ops = '0; start = 1'b1;
    collect(1'b0, -1, 0, -1);
    checks++;
    if (got_s != "4+5=" || done_c != 4) begin
      failures++;
      $display("FAIL clr_restart: got '%s' done=%0d, want '4+5=' done=4", got_s, done_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_no_term();
    test_stall();
    test_bad_request();
    test_back_to_back();
    test_clr_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expr_string_tx.md
Name: expr_string_tx

Overview:
Transmitter counterpart to the expression-string recogniser. Takes a latched list of decimal operands and operators and emits it one ASCII character per accepted beat, in the form digit (op digit)* with an optional '=' terminator. Drives the character-stream inputs of the recogniser and other stream consumers. Uses a valid/ready handshake so downstream logic can stall the stream.

Parameters:
MAX_TERMS, 8, maximum number of operands per expression (>=1).
TERM_EN, 1, when 1 append '=' (8'h3D) after the last digit.
LEN_W, $clog2(MAX_TERMS+1), width of len (derived, not overridden).

Ports:
clk  in  1  rising-edge clock.
clr  in  1  synchronous active-high reset.
start  in  1  request to transmit; sampled only in IDLE.
len  in  LEN_W  operand count, valid range 1..MAX_TERMS.
digits  in  4*MAX_TERMS  operand i in bits [4i+3:4i]; values 0..9.
ops  in  max(MAX_TERMS-1,1)  bit i is the operator between operand i and i+1: 0='+', 1='*'.
out_char  out  8  ASCII character.
out_valid  out  1  out_char is valid this cycle.
out_ready  in  1  consumer accepts out_char when out_valid && out_ready.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the final character is accepted.
err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset is synchronous and active-high; clr wins over every other input.
- On reset the FSM goes to IDLE, idx=0, and all outputs are 0: out_char=8'h00, out_valid=0, busy=0, done=0, err=0.
- FSM states: IDLE, DIGIT, OP, TERM, FIN.
- IDLE, start=1 and request valid:
  - latch len, digits and ops into internal registers; set idx=0; go to DIGIT.
  - out_valid rises on the next cycle (1-cycle start latency).
- IDLE, start=1 and request invalid (len==0, len>MAX_TERMS, or any digit[i]>9 for i<len):
  - err=1 for one cycle; stay in IDLE; nothing is emitted.
  - Digits at positions >= len are ignored.
- DIGIT: out_valid=1, out_char=8'h30+digit[idx].
  - On accept: if idx==len-1, go to TERM when TERM_EN=1, else FIN.
  - Otherwise go to OP.
- OP: out_valid=1, out_char = op[idx] ? 8'h2A ('*') : 8'h2B ('+').
  - On accept: idx<=idx+1, go to DIGIT.
- TERM: out_valid=1, out_char=8'h3D; on accept go to FIN.
- FIN: done=1, out_valid=0; next cycle go to IDLE.
- Without accept, the state holds and out_char stays stable while out_valid=1 (AXI-style).
  - out_valid and out_char depend only on registered state: no combinational path from out_ready.
- out_char=8'h00 whenever out_valid=0.
- Character count is 2*len-1, plus 1 when TERM_EN=1.
  - With out_ready held at 1, one character per cycle and done appears 1 cycle after the last accept.
- start while busy is ignored; latched operands are never disturbed mid-stream.
- start is honoured in the cycle after FIN, when the FSM is back in IDLE.
- len==1: no OP state is ever entered.
- Reset mid-stream: the next edge returns to IDLE with outputs 0. No done pulse is generated and the partial expression is abandoned.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A, CH_EQ=8'h3D.
  - The operator encoding (0=plus, 1=mul).
  - The tx state enum.
- Natural sub-module: expr_req_check. Combinational; takes len/digits and returns req_ok. It is reused by any future expression producer.

Test Plan:
- len=3, digits={3,2,1} (op0 idx0=1), ops=2'b10, TERM_EN=1, ready=1 -> chars "1","+","2","*","3","=" on 6 consecutive cycles starting 1 cycle after start; done pulse 1 cycle after '='; when fed to the recogniser its out=1 after each digit.
- len=1, digit0=7, TERM_EN=0 -> single char 8'h37, then done; OP never entered.
- Same as case 1 with out_ready low for 3 cycles during the OP beat -> '+' held stable with out_valid=1 across the stall; total sequence unchanged.
- digit1=4'hA with len=2 -> err pulse, out_valid stays 0, busy stays 0; the same value at index 5 with len=2 -> accepted.
- start pulsed again during the stream with different digits -> ignored, original string emitted; start in the cycle after FIN -> new stream starts.
- clr asserted while emitting the second character -> next cycle out_valid=0, busy=0, out_char=0, no done; a subsequent start transmits normally.
